// File: rtl/dm_byte_mem.sv
// dm_byte_mem: byte-addressable data memory for the MEM stage.
// Byte/half/word loads and stores with sign/zero extension, a registered
// read port with a one-cycle valid strobe, a zero-fill sweep after clr and
// a combinational word-wide display port for the board viewer.
// Optional feature macro: DM_MISALIGN_TRAP_EN (misaligned access trapping).
// When the macro is undefined, half/word accesses are forced aligned and
// misalign is tied low.

module dm_byte_mem #(
  parameter int WORDS          = 64,
  parameter int ADDR_W         = $clog2(WORDS) + 2,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              sel,
  input  logic              load,
  input  logic              str,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              rvalid,
  output logic              ready,
  output logic              misalign,
  input  logic [ADDR_W-3:0] disp_addr,
  output logic [31:0]       disp_data
);

  localparam int IDX_W = ADDR_W - 2;

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] cnt;
  logic             run;
  logic [31:0]      mem [WORDS];

  logic             is_half;
  logic             is_word;
  logic             mis_access;
  logic             do_load;
  logic             do_store;
  logic [IDX_W-1:0] widx;
  logic [1:0]       lane;
  logic [3:0]       be;
  logic [31:0]      wlanes;
  logic [31:0]      old_word;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic [31:0]      ld_val;

  // run stays low while clr is high and rises on the first edge after it,
  // so ready can never be high during reset without using clr as data.
  assign ready     = run && (state == IDLE);
  assign disp_data = mem[disp_addr];

  // Decode the request: lane enables, lane-replicated store data,
  // misalignment and the extended load value from the pre-store word.
  always_comb begin
    is_half  = (size == 2'b01);
    is_word  = size[1];
    widx     = addr[ADDR_W-1:2];
    lane     = addr[1:0];
    be       = 4'b0000;
    wlanes   = wdata;
    old_word = mem[widx];
    byte_sel = 8'(old_word >> {lane, 3'b000});
    half_sel = 16'(old_word >> {addr[1], 4'b0000});
    ld_val   = old_word;
`ifdef DM_MISALIGN_TRAP_EN
    mis_access = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
`else
    mis_access = 1'b0;
`endif
    if (is_word) begin
      be     = 4'b1111;
      wlanes = wdata;
      ld_val = old_word;
    end else if (is_half) begin
      be     = addr[1] ? 4'b1100 : 4'b0011;
      wlanes = {2{wdata[15:0]}};
      ld_val = unsigned_ld ? {16'h0000, half_sel} : {{16{half_sel[15]}}, half_sel};
    end else begin
      be     = 4'b0001 << lane;
      wlanes = {4{wdata[7:0]}};
      ld_val = unsigned_ld ? {24'h000000, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
    end
    if (mis_access) begin
      ld_val = 32'h0000_0000;
    end
    do_load  = sel && load && ready;
    do_store = sel && str && ready && !mis_access;
  end

  // Sweep/idle controller: CLEAR walks cnt over every word, then IDLE.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      if (CLEAR_ON_RESET) begin
        state <= CLEAR;
      end else begin
        state <= IDLE;
      end
      cnt <= '0;
      run <= 1'b0;
    end else begin
      run <= 1'b1;
      case (state)
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (&cnt) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Storage: zero-fill during the sweep, lane-masked stores when idle.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[cnt] <= 32'h0000_0000;
    end else if (do_store) begin
      for (int l = 0; l < 4; l++) begin
        if (be[l]) begin
          mem[widx][8*l +: 8] <= wlanes[8*l +: 8];
        end
      end
    end
  end

  // Registered read port: rdata holds until the next accepted load.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rdata  <= 32'h0000_0000;
      rvalid <= 1'b0;
    end else begin
      rvalid <= do_load;
      if (do_load) begin
        rdata <= ld_val;
      end
    end
  end

`ifdef DM_MISALIGN_TRAP_EN
  // One-cycle misalign pulse for any accepted misaligned load or store.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      misalign <= 1'b0;
    end else begin
      misalign <= sel && ready && (load || str) && mis_access;
    end
  end
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_dm_byte_mem.sv
// tb_dm_byte_mem: scoreboard bench for dm_byte_mem.
// Stimulus pushes expected responses into a queue computed from a byte-array
// model; a negedge monitor pops and compares whenever rvalid or misalign is
// presented. Display port and sweep timing are checked directly.

`timescale 1ns/1ps

module tb_dm_byte_mem;

  localparam int WORDS = 64;
  localparam int AW    = $clog2(WORDS) + 2;
  localparam int NB    = WORDS * 4;

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic          sel = 1'b0;
  logic          load = 1'b0;
  logic          str = 1'b0;
  logic [1:0]    size = 2'b00;
  logic          unsigned_ld = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [31:0]   wdata = 32'h0;
  logic [31:0]   rdata;
  logic          rvalid;
  logic          ready;
  logic          misalign;
  logic [AW-3:0] disp_addr = '0;
  logic [31:0]   disp_data;

  int checks   = 0;
  int failures = 0;
  bit tb_ready = 1'b0;

  logic [7:0] mmem [NB];

  typedef struct {
    bit          is_load;
    logic [31:0] data;
    bit          mis;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  dm_byte_mem #(.WORDS(WORDS)) dut (
    .clk         (clk),
    .clr         (clr),
    .sel         (sel),
    .load        (load),
    .str         (str),
    .size        (size),
    .unsigned_ld (unsigned_ld),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .rvalid      (rvalid),
    .ready       (ready),
    .misalign    (misalign),
    .disp_addr   (disp_addr),
    .disp_data   (disp_data)
  );

  always #5 clk = ~clk;

  task automatic check_output(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic int nbytes(logic [1:0] sz);
    if (sz == 2'b00) return 1;
    if (sz == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit is_mis(logic [1:0] sz, int a);
`ifdef DM_MISALIGN_TRAP_EN
    return (a % nbytes(sz)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] mword(int w);
    return {mmem[4*w+3], mmem[4*w+2], mmem[4*w+1], mmem[4*w]};
  endfunction

  // Little-endian gather of n bytes from the naturally aligned base.
  function automatic logic [31:0] model_load(logic [1:0] sz, bit uns, int a);
    int n;
    int base;
    logic [31:0] v;
    n    = nbytes(sz);
    base = a - (a % n);
    v    = 32'h0;
    for (int k = 0; k < n; k++) begin
      v = v | (32'(mmem[base+k]) << (8*k));
    end
    if (!uns && n < 4 && v[8*n-1]) begin
      v = v | (32'hFFFF_FFFF << (8*n));
    end
    return v;
  endfunction

  task automatic model_store(logic [1:0] sz, int a, logic [31:0] wd);
    int n;
    int base;
    n    = nbytes(sz);
    base = a - (a % n);
    for (int k = 0; k < n; k++) begin
      mmem[base+k] = wd[8*k +: 8];
    end
  endtask

  // Drive one request for one cycle; predict its response if it will be accepted.
  task automatic apply_stimulus(bit s, bit ld, bit st, logic [1:0] sz, bit uns,
                                int a, logic [31:0] wd);
    bit m;
    @(posedge clk);
    #1;
    sel         = s;
    load        = ld;
    str         = st;
    size        = sz;
    unsigned_ld = uns;
    addr        = AW'(a);
    wdata       = wd;
    if (tb_ready && s && (ld || st)) begin
      m = is_mis(sz, a);
      if (ld) begin
        exp_q.push_back('{is_load: 1'b1, data: (m ? 32'h0 : model_load(sz, uns, a)), mis: m});
      end else if (m) begin
        exp_q.push_back('{is_load: 1'b0, data: 32'h0, mis: 1'b1});
      end
      if (st && !m) begin
        model_store(sz, a, wd);
      end
    end
  endtask

  task automatic idle_cycle();
    apply_stimulus(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 0, 32'h0);
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #1;
    clr      = 1'b1;
    tb_ready = 1'b0;
    @(negedge clk);
    check_output("clr_rdata", rdata, 32'h0);
    check_output("clr_rvalid", {31'b0, rvalid}, 32'h0);
    check_output("clr_ready", {31'b0, ready}, 32'h0);
    check_output("clr_misalign", {31'b0, misalign}, 32'h0);
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  // Count cycles with ready low after clr falls; bounded so it cannot hang.
  task automatic wait_sweep();
    int n;
    n = 0;
    @(negedge clk);
    while (ready !== 1'b1 && n < 300) begin
      n++;
      @(negedge clk);
    end
    sel  = 1'b0;
    load = 1'b0;
    str  = 1'b0;
    check_output("sweep_cycles", 32'(n), 32'(WORDS));
    foreach (mmem[i]) mmem[i] = 8'h00;
    tb_ready = 1'b1;
  endtask

  task automatic disp_all(string name);
    for (int w = 0; w < WORDS; w++) begin
      disp_addr = (AW-2)'(w);
      #1;
      check_output(name, disp_data, mword(w));
    end
  endtask

  task automatic random_ops(int count);
    for (int i = 0; i < count; i++) begin
      int op;
      op = $urandom_range(0, 3);
      apply_stimulus(($urandom_range(0, 9) != 0), (op == 1 || op == 3), (op >= 2),
                     2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     $urandom_range(0, NB-1), $urandom);
    end
  endtask

  // Monitor: compare every presented response against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (rvalid === 1'b1 || misalign === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_response: rvalid=%b misalign=%b rdata=%h, expected no response",
                   rvalid, misalign, rdata);
        end else begin
          mon_e = exp_q.pop_front();
          check_output("resp_rvalid", {31'b0, rvalid}, {31'b0, mon_e.is_load});
          if (mon_e.is_load) begin
            check_output("resp_rdata", rdata, mon_e.data);
          end
          check_output("resp_misalign", {31'b0, misalign}, {31'b0, mon_e.mis});
        end
      end
    end
  end

  initial begin
    $display("[TB] start");
    pulse_clr();
    wait_sweep();
    disp_all("disp_after_sweep");

    // Word store and load back.
    apply_stimulus(1, 0, 1, 2'b10, 0, 'h10, 32'hDEADBEEF);
    apply_stimulus(1, 1, 0, 2'b10, 0, 'h10, 32'h0);
    idle_cycle();

    // Byte store over a known word, then signed/unsigned/word loads.
    apply_stimulus(1, 0, 1, 2'b10, 0, 'h10, 32'h11223344);
    apply_stimulus(1, 0, 1, 2'b00, 0, 'h13, 32'h00000080);
    apply_stimulus(1, 1, 0, 2'b00, 0, 'h13, 32'h0);
    apply_stimulus(1, 1, 0, 2'b00, 1, 'h13, 32'h0);
    apply_stimulus(1, 1, 0, 2'b10, 0, 'h10, 32'h0);
    apply_stimulus(1, 1, 0, 2'b01, 0, 'h12, 32'h0);
    idle_cycle();

    // Same-cycle load and store: load sees old data; display updates after the edge.
    disp_addr = 6'd8;
    apply_stimulus(1, 0, 1, 2'b10, 0, 'h20, 32'h00001234);
    apply_stimulus(1, 1, 1, 2'b10, 0, 'h20, 32'h00000055);
    @(negedge clk);
    check_output("disp_before_edge", disp_data, 32'h00001234);
    apply_stimulus(1, 1, 0, 2'b10, 0, 'h20, 32'h0);
    @(negedge clk);
    check_output("disp_after_edge", disp_data, 32'h00000055);

    // Deselected and unaligned half accesses around word 0.
    apply_stimulus(0, 1, 1, 2'b10, 0, 'h00, 32'hFFFFFFFF);
    apply_stimulus(1, 0, 1, 2'b10, 0, 'h00, 32'hCAFEF00D);
    apply_stimulus(1, 0, 1, 2'b01, 0, 'h01, 32'h0000ABCD);
    apply_stimulus(1, 1, 0, 2'b01, 1, 'h03, 32'h0);
    apply_stimulus(1, 1, 0, 2'b11, 0, 'h02, 32'h0);
    idle_cycle();
    idle_cycle();
    disp_addr = 6'd0;
    #1;
    check_output("disp_word0", disp_data, mword(0));

    random_ops(400);
    idle_cycle();
    idle_cycle();
    disp_all("disp_after_random");

    // clr mid-sweep with requests held: nothing accepted, sweep restarts.
    pulse_clr();
    sel   = 1'b1;
    load  = 1'b1;
    str   = 1'b1;
    size  = 2'b10;
    addr  = AW'('h44);
    wdata = 32'hFFFFFFFF;
    repeat (29) @(posedge clk);
    #2;
    disp_addr = 6'd28;
    #1;
    check_output("sweep_partial_cleared", disp_data, 32'h0);
    disp_addr = 6'd29;
    #1;
    check_output("sweep_partial_old", disp_data, mword(29));
    pulse_clr();
    wait_sweep();
    disp_all("disp_after_restart");

    random_ops(150);
    repeat (4) idle_cycle();
    disp_all("disp_final");
    check_output("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
